time_setter: RTL and testbench

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter_pkg.sv | 36 +++
 rtl/btn_conditioner.sv | 64 ++++++
 rtl/time_setter.sv | 139 +++++++++++++
 tb/tb_time_setter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_setter_pkg.sv
// Shared types and limits for the time-setting front panel.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package time_setter_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        SET_SEC  = 3'd3,
        APPLY    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_t;

    localparam logic [5:0] MAX_HOUR   = 6'd23;
    localparam logic [5:0] MAX_MINSEC = 6'd59;

    // Out-of-range digits or values collapse to 0 so the edit starts from a legal time.
    function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens,
                                              input logic [3:0] units,
                                              input logic [5:0] max_val);
        logic [6:0] val;
        val = {3'b000, tens} * 7'd10 + {3'b000, units};
        if (tens > 4'd9 || units > 4'd9 || val > {1'b0, max_val})
            return 6'd0;
        else
            return val[5:0];
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Button synchronizer + rising-edge detect with optional hold-to-repeat pulses.
// Latency: raw level sampled at edge k yields a one-cycle press acted on at edge k+2.
// Backpressure: none; press pulses are fire-and-forget.
module btn_conditioner #(
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);

    logic          sync1, sync2, prev;
    logic          primed, armed;
    logic [CW-1:0] rpt_cnt;
    logic          rpt_phase;
    logic [CW-1:0] rpt_target;
    logic          edge_ev, rpt_ev;

    // armed only after sync1 has really sampled the pin low, so a button
    // held through reset never looks like a fresh press.
    assign edge_ev    = armed & sync2 & ~prev;
    assign rpt_target = rpt_phase ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
    assign rpt_ev     = REPEAT_EN & armed & sync2 & (rpt_cnt != '0) & (rpt_cnt == rpt_target);
    assign press      = edge_ev | rpt_ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            prev   <= sync2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~sync1);
        end
    end

    // rpt_cnt counts cycles since the last step; zero means not repeating.
    always_ff @(posedge clk) begin
        if (reset || !sync2 || !REPEAT_EN) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else if (edge_ev) begin
            rpt_cnt   <= CW'(1);
            rpt_phase <= 1'b0;
        end else if (rpt_ev) begin
            rpt_cnt   <= CW'(1);
            rpt_phase <= 1'b1;
        end else if (rpt_cnt != '0) begin
            rpt_cnt   <= rpt_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/time_setter.sv
// Three-button hour/min/sec editor producing a one-cycle load strobe for the clock counter.
// Latency: button press acts 2 cycles after first sample; adjust pulses the cycle after the final mode.
// Backpressure: none; the clock counter must accept adjust whenever it pulses.
module time_setter
    import time_setter_pkg::*;
#(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int TIMEOUT      = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_hour_tens,
    input  logic [3:0] cur_hour_units,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_units,
    input  logic [3:0] cur_sec_tens,
    input  logic [3:0] cur_sec_units,
    output logic       adjust,
    output logic [5:0] adjust_hour,
    output logic [5:0] adjust_min,
    output logic [5:0] adjust_sec,
    output logic       editing,
    output logic [1:0] field_sel
);

    localparam int TW = $clog2(TIMEOUT + 1);

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_val);
        return (v >= max_val) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max_val);
        return (v == 6'd0 || v > max_val) ? max_val : v - 6'd1;
    endfunction

    logic          mode_ev, inc_ev, dec_ev;
    state_t        state, next_state;
    logic [5:0]    hour_r, min_r, sec_r;
    logic [TW-1:0] tcnt;
    logic          in_set, any_ev, step_up, step_dn, timeout_hit;
    logic          adjust_d, editing_d;
    field_t        field_d;

    btn_conditioner #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_mode (.clk(clk), .reset(reset), .btn(btn_mode), .press(mode_ev));
    btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_inc  (.clk(clk), .reset(reset), .btn(btn_inc),  .press(inc_ev));
    btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
        u_dec  (.clk(clk), .reset(reset), .btn(btn_dec),  .press(dec_ev));

    // Mode beats inc/dec; simultaneous inc and dec cancel out.
    assign in_set      = (state == SET_HOUR) || (state == SET_MIN) || (state == SET_SEC);
    assign any_ev      = mode_ev | inc_ev | dec_ev;
    assign step_up     = in_set & ~mode_ev & inc_ev & ~dec_ev;
    assign step_dn     = in_set & ~mode_ev & dec_ev & ~inc_ev;
    assign timeout_hit = in_set & ~any_ev & (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            adjust    <= 1'b0;
            editing   <= 1'b0;
            field_sel <= FIELD_NONE;
        end else begin
            state     <= next_state;
            adjust    <= adjust_d;
            editing   <= editing_d;
            field_sel <= field_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (mode_ev) next_state = SET_HOUR;
            SET_HOUR: if (mode_ev) next_state = SET_MIN;  else if (timeout_hit) next_state = IDLE;
            SET_MIN:  if (mode_ev) next_state = SET_SEC;  else if (timeout_hit) next_state = IDLE;
            SET_SEC:  if (mode_ev) next_state = APPLY;    else if (timeout_hit) next_state = IDLE;
            APPLY:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Decoded from next_state so the registered outputs line up with state.
    always_comb begin
        adjust_d  = 1'b0;
        editing_d = 1'b0;
        field_d   = FIELD_NONE;
        case (next_state)
            SET_HOUR: begin editing_d = 1'b1; field_d = FIELD_HOUR; end
            SET_MIN:  begin editing_d = 1'b1; field_d = FIELD_MIN;  end
            SET_SEC:  begin editing_d = 1'b1; field_d = FIELD_SEC;  end
            APPLY:    adjust_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !in_set || any_ev)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hour_r <= 6'd0;
            min_r  <= 6'd0;
            sec_r  <= 6'd0;
        end else if (state == IDLE && mode_ev) begin
            hour_r <= bcd_to_bin(cur_hour_tens, cur_hour_units, MAX_HOUR);
            min_r  <= bcd_to_bin(cur_min_tens,  cur_min_units,  MAX_MINSEC);
            sec_r  <= bcd_to_bin(cur_sec_tens,  cur_sec_units,  MAX_MINSEC);
        end else if (step_up) begin
            case (state)
                SET_HOUR: hour_r <= wrap_inc(hour_r, MAX_HOUR);
                SET_MIN:  min_r  <= wrap_inc(min_r,  MAX_MINSEC);
                SET_SEC:  sec_r  <= wrap_inc(sec_r,  MAX_MINSEC);
                default:  ;
            endcase
        end else if (step_dn) begin
            case (state)
                SET_HOUR: hour_r <= wrap_dec(hour_r, MAX_HOUR);
                SET_MIN:  min_r  <= wrap_dec(min_r,  MAX_MINSEC);
                SET_SEC:  sec_r  <= wrap_dec(sec_r,  MAX_MINSEC);
                default:  ;
            endcase
        end
    end

    assign adjust_hour = hour_r;
    assign adjust_min  = min_r;
    assign adjust_sec  = sec_r;

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter with short repeat/timeout parameters.
module tb_time_setter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [3:0] cht = 4'd0, chu = 4'd0, cmt = 4'd0, cmu = 4'd0, cst = 4'd0, csu = 4'd0;
    logic       adjust, editing;
    logic [5:0] adjust_hour, adjust_min, adjust_sec;
    logic [1:0] field_sel;

    int checks = 0;
    int errors = 0;
    int adj_pulses = 0;
    logic [5:0] adj_h = 6'd0, adj_m = 6'd0, adj_s = 6'd0;

    time_setter #(.REPEAT_DELAY(8), .REPEAT_RATE(4), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_hour_tens(cht), .cur_hour_units(chu),
        .cur_min_tens(cmt),  .cur_min_units(cmu),
        .cur_sec_tens(cst),  .cur_sec_units(csu),
        .adjust(adjust), .adjust_hour(adjust_hour), .adjust_min(adjust_min),
        .adjust_sec(adjust_sec), .editing(editing), .field_sel(field_sel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (adjust) begin
            adj_pulses++;
            adj_h = adjust_hour;
            adj_m = adjust_min;
            adj_s = adjust_sec;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        tick(3);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick(3);
    endtask

    task automatic set_cur(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
        cht = a; chu = b; cmt = c; cmu = d; cst = e; csu = f;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (adjust !== 1'b0)      begin errors++; $display("FAIL rst_adjust got %0d want 0", adjust); end
        checks++; if (editing !== 1'b0)     begin errors++; $display("FAIL rst_editing got %0d want 0", editing); end
        checks++; if (field_sel !== 2'd0)   begin errors++; $display("FAIL rst_field got %0d want 0", field_sel); end
        checks++; if (adjust_hour !== 6'd0) begin errors++; $display("FAIL rst_hour got %0d want 0", adjust_hour); end
        checks++; if (adjust_min !== 6'd0)  begin errors++; $display("FAIL rst_min got %0d want 0", adjust_min); end
        checks++; if (adjust_sec !== 6'd0)  begin errors++; $display("FAIL rst_sec got %0d want 0", adjust_sec); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_set();
        int p0;
        p0 = adj_pulses;
        set_cur(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        press(1, 0, 0);
        checks++; if (editing !== 1'b1)      begin errors++; $display("FAIL set_editing got %0d want 1", editing); end
        checks++; if (field_sel !== 2'd1)    begin errors++; $display("FAIL set_field_h got %0d want 1", field_sel); end
        checks++; if (adjust_hour !== 6'd12) begin errors++; $display("FAIL set_cap_hour got %0d want 12", adjust_hour); end
        checks++; if (adjust_sec !== 6'd56)  begin errors++; $display("FAIL set_cap_sec got %0d want 56", adjust_sec); end
        press(0, 1, 0);
        press(0, 1, 0);
        checks++; if (adjust_hour !== 6'd14) begin errors++; $display("FAIL set_hour_inc got %0d want 14", adjust_hour); end
        press(1, 0, 0);
        checks++; if (field_sel !== 2'd2)    begin errors++; $display("FAIL set_field_m got %0d want 2", field_sel); end
        press(0, 0, 1);
        checks++; if (adjust_min !== 6'd33)  begin errors++; $display("FAIL set_min_dec got %0d want 33", adjust_min); end
        press(1, 0, 0);
        checks++; if (field_sel !== 2'd3)    begin errors++; $display("FAIL set_field_s got %0d want 3", field_sel); end
        checks++; if (adj_pulses !== p0)     begin errors++; $display("FAIL set_early_adjust got %0d want %0d", adj_pulses, p0); end
        press(1, 0, 0);
        checks++; if (adj_pulses !== p0 + 1) begin errors++; $display("FAIL set_pulses got %0d want %0d", adj_pulses, p0 + 1); end
        checks++; if ({adj_h, adj_m, adj_s} !== {6'd14, 6'd33, 6'd56})
            begin errors++; $display("FAIL set_applied got %0d:%0d:%0d want 14:33:56", adj_h, adj_m, adj_s); end
        checks++; if (editing !== 1'b0)      begin errors++; $display("FAIL set_idle got %0d want 0", editing); end
    endtask

    task automatic test_wrap();
        set_cur(4'd2, 4'd3, 4'd0, 4'd0, 4'd5, 4'd9);
        press(1, 0, 0);
        press(0, 1, 0);
        checks++; if (adjust_hour !== 6'd0)  begin errors++; $display("FAIL wrap_hour got %0d want 0", adjust_hour); end
        press(1, 0, 0);
        press(0, 0, 1);
        checks++; if (adjust_min !== 6'd59)  begin errors++; $display("FAIL wrap_min got %0d want 59", adjust_min); end
        press(1, 0, 0);
        press(0, 1, 0);
        checks++; if (adjust_sec !== 6'd0)   begin errors++; $display("FAIL wrap_sec got %0d want 0", adjust_sec); end
        press(1, 0, 0);
        checks++; if ({adj_h, adj_m, adj_s} !== {6'd0, 6'd59, 6'd0})
            begin errors++; $display("FAIL wrap_applied got %0d:%0d:%0d want 0:59:0", adj_h, adj_m, adj_s); end
    endtask

    task automatic test_repeat();
        set_cur(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
        press(1, 0, 0);
        press(1, 0, 0);
        checks++; if (adjust_min !== 6'd10)  begin errors++; $display("FAIL rpt_start got %0d want 10", adjust_min); end
        // Synchronized level stays high for the press cycle plus 20 more.
        btn_inc = 1'b1;
        tick(21);
        btn_inc = 1'b0;
        tick(3);
        checks++; if (adjust_min !== 6'd15)  begin errors++; $display("FAIL rpt_min got %0d want 15", adjust_min); end
        tick(10);
        checks++; if (adjust_min !== 6'd15)  begin errors++; $display("FAIL rpt_release got %0d want 15", adjust_min); end
        press(1, 0, 0);
        press(1, 0, 0);
        checks++; if (adj_m !== 6'd15)       begin errors++; $display("FAIL rpt_applied got %0d want 15", adj_m); end
    endtask

    task automatic test_conflict();
        int p0;
        set_cur(4'd0, 4'd5, 4'd2, 4'd0, 4'd3, 4'd0);
        press(1, 0, 0);
        press(0, 1, 1);
        checks++; if (adjust_hour !== 6'd5)  begin errors++; $display("FAIL cfl_incdec got %0d want 5", adjust_hour); end
        press(1, 1, 0);
        checks++; if (field_sel !== 2'd2)    begin errors++; $display("FAIL cfl_mode_field got %0d want 2", field_sel); end
        checks++; if (adjust_hour !== 6'd5)  begin errors++; $display("FAIL cfl_mode_hour got %0d want 5", adjust_hour); end
        press(0, 1, 0);
        checks++; if (adjust_min !== 6'd21)  begin errors++; $display("FAIL cfl_min got %0d want 21", adjust_min); end
        p0 = adj_pulses;
        press(1, 0, 0);
        press(1, 0, 0);
        checks++; if (adj_pulses !== p0 + 1) begin errors++; $display("FAIL cfl_pulses got %0d want %0d", adj_pulses, p0 + 1); end
        // inc in IDLE is ignored.
        press(0, 1, 0);
        checks++; if (adjust_min !== 6'd21)  begin errors++; $display("FAIL cfl_idle_inc got %0d want 21", adjust_min); end
    endtask

    task automatic test_timeout();
        int p0;
        p0 = adj_pulses;
        set_cur(4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd3);
        press(1, 0, 0);
        press(1, 0, 0);
        checks++; if (field_sel !== 2'd2)    begin errors++; $display("FAIL to_field got %0d want 2", field_sel); end
        // Entry edge was 3 ticks ago; 49 edges after entry still editing.
        tick(46);
        checks++; if (editing !== 1'b1)      begin errors++; $display("FAIL to_early got %0d want 1", editing); end
        tick(1);
        checks++; if (editing !== 1'b0)      begin errors++; $display("FAIL to_expire got %0d want 0", editing); end
        checks++; if (field_sel !== 2'd0)    begin errors++; $display("FAIL to_field_none got %0d want 0", field_sel); end
        tick(3);
        checks++; if (adj_pulses !== p0)     begin errors++; $display("FAIL to_adjust got %0d want %0d", adj_pulses, p0); end
    endtask

    task automatic test_reset_midedit();
        int p0;
        p0 = adj_pulses;
        set_cur(4'd0, 4'd9, 4'd0, 4'd8, 4'd0, 4'd7);
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        checks++; if (field_sel !== 2'd3)    begin errors++; $display("FAIL mid_field got %0d want 3", field_sel); end
        reset = 1'b1;
        tick(1);
        checks++; if (editing !== 1'b0)      begin errors++; $display("FAIL mid_editing got %0d want 0", editing); end
        checks++; if (adjust_sec !== 6'd0)   begin errors++; $display("FAIL mid_sec got %0d want 0", adjust_sec); end
        reset = 1'b0;
        tick(3);
        checks++; if (adj_pulses !== p0)     begin errors++; $display("FAIL mid_adjust got %0d want %0d", adj_pulses, p0); end
        // Invalid captures: hour 99, sec units 10.
        set_cur(4'd9, 4'd9, 4'd4, 4'd5, 4'd0, 4'd10);
        press(1, 0, 0);
        checks++; if (adjust_hour !== 6'd0)  begin errors++; $display("FAIL inv_hour got %0d want 0", adjust_hour); end
        checks++; if (adjust_min !== 6'd45)  begin errors++; $display("FAIL inv_min got %0d want 45", adjust_min); end
        checks++; if (adjust_sec !== 6'd0)   begin errors++; $display("FAIL inv_sec got %0d want 0", adjust_sec); end
        do_reset();
    endtask

    task automatic test_held_reset();
        btn_mode = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        checks++; if (editing !== 1'b0)      begin errors++; $display("FAIL held_editing got %0d want 0", editing); end
        btn_mode = 1'b0;
        tick(3);
        press(1, 0, 0);
        checks++; if (editing !== 1'b1)      begin errors++; $display("FAIL held_rearm got %0d want 1", editing); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_set();
        test_wrap();
        test_repeat();
        test_conflict();
        test_timeout();
        test_reset_midedit();
        test_held_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
